// File: rtl/pipe3_seq_pkg.sv
// Shared types and default sizing for the three-stage increment sequencer.
package pipe3_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pipe3_datapath.sv
// Three chained increment registers with per-stage valid bits, driven by the
// sequencer's load / issue / shift / clear controls.
module pipe3_datapath
  import pipe3_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_issue,
  input  logic             i_shift,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_stage1,
  output logic [WIDTH-1:0] o_stage2,
  output logic [WIDTH-1:0] o_stage3,
  output logic             o_valid1,
  output logic             o_valid2,
  output logic             o_valid3
);

  logic [WIDTH-1:0] r_stage1;
  logic [WIDTH-1:0] r_stage2;
  logic [WIDTH-1:0] r_stage3;
  logic             r_valid1;
  logic             r_valid2;
  logic             r_valid3;

  // A shift without an issue drains stage 1: its data holds but goes invalid.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
      r_stage3 <= '0;
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
      r_valid3 <= 1'b0;
    end else if (i_clear) begin
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
      r_valid3 <= 1'b0;
    end else begin
      if (i_load) begin
        r_stage1 <= i_seed;
        r_valid1 <= 1'b1;
      end else if (i_issue) begin
        r_stage1 <= r_stage1 + 1'b1;
        r_valid1 <= 1'b1;
      end else if (i_shift) begin
        r_valid1 <= 1'b0;
      end
      if (i_shift) begin
        r_stage2 <= r_stage1 + 1'b1;
        r_valid2 <= r_valid1;
        r_stage3 <= r_stage2 + 1'b1;
        r_valid3 <= r_valid2;
      end
    end
  end

  assign o_stage1 = r_stage1;
  assign o_stage2 = r_stage2;
  assign o_stage3 = r_stage3;
  assign o_valid1 = r_valid1;
  assign o_valid2 = r_valid2;
  assign o_valid3 = r_valid3;

endmodule

// File: rtl/pipe3_sequencer.sv
// Burst controller: accepts (seed, length), issues a counted run into the
// datapath, drains it and pulses done for one cycle.
module pipe3_sequencer
  import pipe3_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             stall_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o1,
  output logic [WIDTH-1:0] out_o2,
  output logic [WIDTH-1:0] out_o3,
  output logic             valid_o1,
  output logic             valid_o2,
  output logic             valid_o3
);

  state_t           r_state;
  state_t           w_nextState;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] w_nextRemaining;
  logic [LEN_W-1:0] w_lenMinus1;
  logic             w_load;
  logic             w_issue;
  logic             w_shift;
  logic             w_clear;
  logic             w_valid1;
  logic             w_valid2;
  logic             w_valid3;

  // len=0 wraps to all ones, which is exactly 2^LEN_W - 1 further issues.
  assign w_lenMinus1 = len_i - 1'b1;

  always_comb begin
    w_nextState     = r_state;
    w_nextRemaining = r_remaining;
    w_load          = 1'b0;
    w_issue         = 1'b0;
    w_shift         = 1'b0;
    w_clear         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_load          = 1'b1;
          w_nextRemaining = w_lenMinus1;
          w_nextState     = (w_lenMinus1 != '0) ? FILL : DRAIN;
        end
      end
      FILL: begin
        if (abort_i) begin
          w_clear         = 1'b1;
          w_nextRemaining = '0;
          w_nextState     = IDLE;
        end else if (!stall_i) begin
          w_issue         = 1'b1;
          w_shift         = 1'b1;
          w_nextRemaining = r_remaining - 1'b1;
          if (r_remaining == LEN_W'(1)) begin
            w_nextState = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort_i) begin
          w_clear         = 1'b1;
          w_nextRemaining = '0;
          w_nextState     = IDLE;
        end else if (!stall_i) begin
          w_shift = 1'b1;
          if (!w_valid1 && !w_valid2) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        if (abort_i) begin
          w_clear         = 1'b1;
          w_nextRemaining = '0;
          w_nextState     = IDLE;
        end else begin
          w_shift     = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state     <= IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_nextState;
      r_remaining <= w_nextRemaining;
    end
  end

  pipe3_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .i_load  (w_load),
    .i_seed  (seed_i),
    .i_issue (w_issue),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .o_stage1(out_o1),
    .o_stage2(out_o2),
    .o_stage3(out_o3),
    .o_valid1(w_valid1),
    .o_valid2(w_valid2),
    .o_valid3(w_valid3)
  );

  assign valid_o1 = w_valid1;
  assign valid_o2 = w_valid2;
  assign valid_o3 = w_valid3;
  assign ready_o  = (r_state == IDLE);
  assign busy_o   = (r_state != IDLE);
  assign done_o   = (r_state == DONE);

endmodule

// File: tb/tb_pipe3_sequencer.sv
// Directed, table-driven bench for pipe3_sequencer with hand-computed
// milestones plus sequences for reset, abort and held-start corner cases.
module tb_pipe3_sequencer;

  logic       clk_i;
  logic       reset_ni;
  logic       start_i;
  logic [3:0] seed_i;
  logic [3:0] len_i;
  logic       stall_i;
  logic       abort_i;
  logic       ready_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] out_o1;
  logic [3:0] out_o2;
  logic [3:0] out_o3;
  logic       valid_o1;
  logic       valid_o2;
  logic       valid_o3;

  int total = 0;
  int bad   = 0;

  logic [3:0] capOut[0:31];
  int         capCnt;
  int         capDoneCnt;
  int         capDoneIdx;
  int         capReadyIdx;
  logic       capBusy0;
  logic       capReady0;

  typedef struct {
    logic [3:0]  seed;
    logic [3:0]  len;
    logic [63:0] stallMask;
    int          expFirst;
    int          expCount;
    int          expDone;
    int          expReady;
  } vec_t;

  vec_t vecs[5];

  pipe3_sequencer dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .start_i (start_i),
    .seed_i  (seed_i),
    .len_i   (len_i),
    .stall_i (stall_i),
    .abort_i (abort_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .out_o1  (out_o1),
    .out_o2  (out_o2),
    .out_o3  (out_o3),
    .valid_o1(valid_o1),
    .valid_o2(valid_o2),
    .valid_o3(valid_o3)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClk();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset_ni = 1'b0;
    start_i  = 1'b0;
    stall_i  = 1'b0;
    abort_i  = 1'b0;
    stepClk();
    reset_ni = 1'b1;
  endtask

  // Index k means "sampled after edge T+k"; stallMask[k] drives edge T+k+1.
  task automatic applyStimulus(input logic [3:0] seed, input logic [3:0] len,
                               input logic [63:0] stallMask, input logic holdStart);
    capCnt      = 0;
    capDoneCnt  = 0;
    capDoneIdx  = -1;
    capReadyIdx = -1;
    seed_i  = seed;
    len_i   = len;
    start_i = 1'b1;
    stall_i = 1'b0;
    stepClk();
    capBusy0  = busy_o;
    capReady0 = ready_o;
    if (!holdStart) start_i = 1'b0;
    for (int idx = 0; idx < 64; idx++) begin
      if (idx > 0 && ready_o) begin
        capReadyIdx = idx;
        break;
      end
      if (done_o) begin
        capDoneCnt++;
        capDoneIdx = idx;
      end
      stall_i = stallMask[idx];
      if (valid_o3 && !stall_i && capCnt < 32) begin
        capOut[capCnt] = out_o3;
        capCnt++;
      end
      stepClk();
    end
    stall_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'd5,  4'd1, 64'h0,  7,  1, 3,  4};
    vecs[1] = '{4'd14, 4'd3, 64'h0,  0,  3, 5,  6};
    vecs[2] = '{4'd3,  4'd4, 64'h46, 5,  4, 9,  10};
    vecs[3] = '{4'd9,  4'd2, 64'h0,  11, 2, 4,  5};
    vecs[4] = '{4'd12, 4'd7, 64'h0,  14, 7, 9,  10};

    seed_i = '0;
    len_i  = '0;
    doReset();

    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_out", {out_o1, out_o2, out_o3}, 0);
    checkOutput("rst_valid", {valid_o1, valid_o2, valid_o3}, 0);

    for (int v = 0; v < 5; v++) begin
      doReset();
      applyStimulus(vecs[v].seed, vecs[v].len, vecs[v].stallMask, 1'b0);
      checkOutput($sformatf("v%0d_busy0", v), capBusy0, 1);
      checkOutput($sformatf("v%0d_ready0", v), capReady0, 0);
      checkOutput($sformatf("v%0d_count", v), capCnt, vecs[v].expCount);
      for (int k = 0; k < capCnt && k < vecs[v].expCount; k++) begin
        checkOutput($sformatf("v%0d_out3_%0d", v, k), capOut[k],
                    (vecs[v].expFirst + k) & 15);
      end
      checkOutput($sformatf("v%0d_donecnt", v), capDoneCnt, 1);
      checkOutput($sformatf("v%0d_doneidx", v), capDoneIdx, vecs[v].expDone);
      checkOutput($sformatf("v%0d_readyidx", v), capReadyIdx, vecs[v].expReady);
    end

    // Reset mid-burst after three of eight issues.
    doReset();
    seed_i  = 4'd2;
    len_i   = 4'd8;
    start_i = 1'b1;
    stepClk();
    start_i = 1'b0;
    stepClk();
    stepClk();
    checkOutput("mid_issued", out_o1, 4);
    checkOutput("mid_busy", busy_o, 1);
    reset_ni = 1'b0;
    stepClk();
    checkOutput("mid_out", {out_o1, out_o2, out_o3}, 0);
    checkOutput("mid_valid", {valid_o1, valid_o2, valid_o3}, 0);
    checkOutput("mid_flags", {ready_o, busy_o, done_o}, 3'b100);
    reset_ni = 1'b1;
    capDoneCnt = 0;
    for (int i = 0; i < 4; i++) begin
      stepClk();
      if (done_o || !ready_o) capDoneCnt++;
    end
    checkOutput("mid_quiet", capDoneCnt, 0);

    // Abort in DRAIN while stages 2 and 3 are valid.
    doReset();
    seed_i  = 4'd6;
    len_i   = 4'd2;
    start_i = 1'b1;
    stepClk();
    start_i = 1'b0;
    stepClk();
    stepClk();
    checkOutput("abt_pre_valid", {valid_o1, valid_o2, valid_o3}, 3'b011);
    abort_i = 1'b1;
    stepClk();
    abort_i = 1'b0;
    checkOutput("abt_valid", {valid_o1, valid_o2, valid_o3}, 0);
    checkOutput("abt_flags", {ready_o, busy_o, done_o}, 3'b100);
    checkOutput("abt_hold", {out_o1, out_o2, out_o3}, {4'd7, 4'd8, 4'd8});
    seed_i  = 4'd1;
    len_i   = 4'd1;
    start_i = 1'b1;
    stepClk();
    start_i = 1'b0;
    checkOutput("abt_restart", {busy_o, valid_o1, out_o1}, {1'b1, 1'b1, 4'd1});

    // len=0 burst with start_i held high throughout.
    doReset();
    applyStimulus(4'd10, 4'd0, 64'h0, 1'b1);
    checkOutput("len0_count", capCnt, 16);
    for (int k = 0; k < capCnt && k < 16; k++) begin
      checkOutput($sformatf("len0_out3_%0d", k), capOut[k], (12 + k) & 15);
    end
    checkOutput("len0_donecnt", capDoneCnt, 1);
    checkOutput("len0_doneidx", capDoneIdx, 18);
    checkOutput("len0_readyidx", capReadyIdx, 19);
    stepClk();
    start_i = 1'b0;
    checkOutput("len0_reaccept", {busy_o, valid_o1, out_o1}, {1'b1, 1'b1, 4'd10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe3_sequencer.md
# pipe3_sequencer

Controller plus datapath for a three-stage increment pipeline. It accepts a burst command (seed, length), issues a counted run of values into stage 1 and drains them through stages 2 and 3. It signals completion with a one-cycle done pulse. Stage updates use strict registered semantics: each stage adds 1 to the previous stage's registered value. It sits between a command source and any consumer of the stage-3 output.

## Interface
- WIDTH, 4: data width of every stage; all arithmetic is modulo 2^WIDTH.
- LEN_W, 4: burst-length field width; the value 0 encodes 2^LEN_W.
- clk_i  in  1  single clock, rising edge.
- reset_ni  in  1  synchronous, active-low reset.
- start_i  in  1  command request; accepted only when ready_o=1.
- seed_i  in  WIDTH  first value loaded into stage 1 on accept.
- len_i  in  LEN_W  burst length; 0 means 2^LEN_W.
- stall_i  in  1  freezes the pipeline and sequencer in FILL/DRAIN.
- abort_i  in  1  cancels the active burst.
- ready_o  out  1  high in IDLE only.
- busy_o  out  1  high in FILL, DRAIN and DONE.
- done_o  out  1  high for exactly the DONE cycle.
- out_o1, out_o2, out_o3  out  WIDTH  stage 1/2/3 registers.
- valid_o1, valid_o2, valid_o3  out  1  per-stage valid bits.

## Operation
- The clock is clk_i. reset_ni is synchronous and active-low.
- Reset (reset_ni=0 at an edge) sets:
  - state to IDLE;
  - every out_o* to 0 and every valid_o* to 0;
  - the remaining-issue counter to 0;
  - done_o=0, busy_o=0, ready_o=1.
- Reset has priority over every other input.
- States and transitions:
  - IDLE: when start_i=1, load stage1=seed_i, set v1=1, remaining=len-1. Go to FILL if remaining>0, else go to DRAIN.
  - FILL: on each non-stalled edge, stage1 <= stage1+1 and v1 <= 1, then remaining decrements. The edge that makes the last issue moves to DRAIN.
  - DRAIN: on each non-stalled edge, v1 <= 0 and stage1 holds. When v1=0 and v2=0 in the current cycle, the next non-stalled edge moves to DONE.
  - DONE: done_o=1 for one cycle, then IDLE. DONE ignores stall_i.
- Shift rule, applied on every non-stalled edge outside IDLE:
  - stage2 <= stage1+1 and v2 <= v1;
  - stage3 <= stage2+1 and v3 <= v2.
  - Data registers shift regardless of valid; consumers qualify on valid_o*.
- In IDLE all registers hold.
- stall_i=1 in FILL or DRAIN holds state, remaining count, data and valids.
- abort_i=1 in FILL, DRAIN or DONE: the next edge clears v1..v3 and goes to IDLE, with no done_o. Data registers hold.
- Priority: reset_ni, then abort_i, then stall_i.
- start_i outside IDLE is ignored and not queued.
- Wrap-around: all additions truncate to WIDTH bits, with no saturation.

## Timing
- Let T be the accepting edge. Valid data appears at each stage as follows:
  - stage 1 (out_o1): after edge T;
  - stage 2 (out_o2 = seed+1): after edge T+1;
  - stage 3 (out_o3 = seed+2): after edge T+2.
- For a burst of N with no stalls:
  - the last issue happens at edge T+N-1;
  - the last valid_o3 appears after edge T+N+1;
  - DONE (done_o=1) runs during the cycle after edge T+N+2;
  - ready_o returns after edge T+N+3.
- Back-to-back: a start_i held high is accepted in the first IDLE cycle, at the earliest 1 cycle after done_o.
- Each stall cycle extends every later milestone by exactly 1 cycle.
- ready_o, busy_o and done_o are registered-state decodes, with no combinational path from inputs.

## Structure
- Package pipe3_seq_pkg holds:
  - the state_t enum {IDLE, FILL, DRAIN, DONE};
  - default WIDTH and LEN_W constants.
- Sub-module pipe3_datapath holds the three data registers and valid bits. Its controls are load (with seed), issue, shift-enable and clear-valid.
- The top level contains the FSM and the remaining-issue counter only.

## Test plan
- Reset mid-burst:
  - Stimulus: reset_ni=0 during FILL, after issuing 3 of 8.
  - Required: after the edge, all outputs are 0, ready_o=1, and no done_o.
- Single element:
  - Stimulus: seed=5, len=1.
  - Required:
    - out_o3=7 with valid_o3=1 after edge T+2;
    - done_o=1 after edge T+3;
    - ready_o=1 after edge T+4.
- Wrap-around:
  - Stimulus: seed=14, len=3.
  - Required: valid out_o3 sequence is 0, 1, 2 on consecutive cycles; done_o exactly once.
- Stall in FILL and DRAIN:
  - Stimulus: len=4, stall_i high for 2 cycles in FILL and 1 cycle in DRAIN.
  - Required: out_o3 sequence unchanged and no duplicates; done_o 3 cycles later than the unstalled case.
- Abort:
  - Stimulus: abort_i during DRAIN with v2=v3=1.
  - Required: all valids 0 and state IDLE next cycle, no done_o, start_i accepted the following cycle.
- Edge length and ignored start:
  - Stimulus: len=0, with start_i held high throughout.
  - Required: exactly 16 valid out_o3 values, seed+2 through seed+17 (mod 16). The held start_i is re-accepted only after done_o.
